// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester-side and serializer-side signals of the UART Tx arbiter.
// The arbiter uses the slave view; the requesters, serializer and benches use the master view.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     i_req;
    logic [8*N-1:0]   i_req_d;
    logic [N-1:0]     o_ack;
    logic [7:0]       o_tx_d;
    logic             o_tx_en;
    logic             i_tx_complete;
    logic [IDX_W-1:0] o_grant_idx;
    logic             o_busy;
    logic             o_timeout;

    modport slave (
        input  i_req, i_req_d, i_tx_complete,
        output o_ack, o_tx_d, o_tx_en, o_grant_idx, o_busy, o_timeout
    );

    modport master (
        output i_req, i_req_d, i_tx_complete,
        input  o_ack, o_tx_d, o_tx_en, o_grant_idx, o_busy, o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART Tx serializer between N byte requesters:
// grant, one-cycle launch, wait for completion (with timeout), then an inter-frame gap.
module uart_tx_arbiter #(
    parameter int N          = 4,
    parameter int TIMEOUT    = 8192,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int IDX_W  = $clog2(N);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam int GCNT_W = $clog2(GAP_CYCLES + 1);

    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX  = WCNT_W'(TIMEOUT);
    localparam logic [GCNT_W-1:0] GAP_LAST  = GCNT_W'(GAP_CYCLES - 1);
    localparam logic [GCNT_W-1:0] GAP_MAX   = GCNT_W'(GAP_CYCLES);
    localparam logic [IDX_W:0]    N_WIDE    = (IDX_W + 1)'(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        tx_d_q, tx_d_d;
    logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
    logic [N-1:0]      ack_q, ack_d;
    logic              tx_en_q, tx_en_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [GCNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic              cpl_prev_q, cpl_prev_d;

    logic              cpl_rise;
    logic              rr_found;
    logic [IDX_W-1:0]  rr_pick;
    logic [IDX_W:0]    rr_sum;
    logic [7:0]        req_byte [N];

    for (genvar g = 0; g < N; g++) begin : g_req_byte
        assign req_byte[g] = bus.i_req_d[8*g +: 8];
    end

    assign cpl_rise = bus.i_tx_complete & ~cpl_prev_q;

    // Search starts one past the last grant and wraps, so the last winner has lowest priority.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_sum   = '0;
        for (int i = 1; i <= N; i++) begin
            rr_sum = {1'b0, grant_idx_q} + (IDX_W + 1)'(i);
            if (rr_sum >= N_WIDE) begin
                rr_sum = rr_sum - N_WIDE;
            end
            if (!rr_found && bus.i_req[rr_sum[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_pick  = rr_sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_d_d      = tx_d_q;
        grant_idx_d = grant_idx_q;
        ack_d       = '0;
        tx_en_d     = 1'b0;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        wait_cnt_d  = wait_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        cpl_prev_d  = bus.i_tx_complete;

        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    state_d     = S_LAUNCH;
                    tx_d_d      = req_byte[rr_pick];
                    grant_idx_d = rr_pick;
                    ack_d       = N'(1) << rr_pick;
                    tx_en_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            S_LAUNCH: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
                // A completion arriving on the last allowed cycle beats the timeout.
                if (cpl_rise) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                    timeout_d = 1'b1;
                end
            end
            S_GAP: begin
                gap_cnt_d = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tx_d_q      <= '0;
            grant_idx_q <= IDX_W'(N - 1);
            ack_q       <= '0;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            wait_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            cpl_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_d_q      <= tx_d_d;
            grant_idx_q <= grant_idx_d;
            ack_q       <= ack_d;
            tx_en_q     <= tx_en_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            wait_cnt_q  <= wait_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            cpl_prev_q  <= cpl_prev_d;
        end
    end

    assign bus.o_ack       = ack_q;
    assign bus.o_tx_d      = tx_d_q;
    assign bus.o_tx_en     = tx_en_q;
    assign bus.o_grant_idx = grant_idx_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_timeout   = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART Tx serializer (8 data bits, start 0, stop 1, 115200 baud at a 50 MHz clock) between N byte requesters. It accepts one byte at a time from the granted requester and issues the single-cycle transmit-enable pulse the serializer expects. It waits for the serializer's completion indication, with a timeout, then inserts an inter-frame gap before the next grant. It sits between the application-side message sources and the UART Tx top.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- TIMEOUT, 8192, cycles allowed in WAIT for completion (one frame ≈ 4340 cycles)
- GAP_CYCLES, 2, idle cycles inserted after each frame (≥1)

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  N  per-requester request level; hold high with data stable until acked
- i_req_d  in  8*N  request bytes; requester k on bits [8k+7:8k]
- o_ack  out  N  one-hot, one-cycle accept pulse to the granted requester
- o_tx_d  out  8  byte to serializer i_tx_d; held from grant until next grant
- o_tx_en  out  1  one-cycle transmit start to serializer i_tx_en
- i_tx_complete  in  1  serializer completion (o_tx_complete); pulse or level, rising edge used
- o_grant_idx  out  clog2(N)  index of last granted requester
- o_busy  out  1  high whenever state ≠ IDLE
- o_timeout  out  1  one-cycle pulse when a frame times out

## Operation
- Reset (async, rst_n=0): state IDLE. o_ack=0, o_tx_en=0, o_tx_d=0, o_busy=0, o_timeout=0, o_grant_idx=N-1, so requester 0 has first priority. Counters cleared and completion edge register cleared. Reset mid-frame abandons the frame; no ack or timeout is emitted.
- Completion detect: register prev ← i_tx_complete every cycle. rise = i_tx_complete & ~prev. rise is acted on only in WAIT; rises in other states are discarded.
- Round-robin: search from (o_grant_idx+1) mod N upward with wrap. The first k with i_req[k]=1 wins. o_grant_idx ← k at grant.
- FSM:
  - IDLE: if any i_req is set, latch o_tx_d ← i_req_d[k] and update o_grant_idx, then go to LAUNCH. Otherwise stay.
  - LAUNCH (exactly 1 cycle): o_ack[k]=1 and o_tx_en=1. Clear the wait counter. Go to WAIT.
  - WAIT: the counter increments each cycle.
    - If rise: go to GAP.
    - Else if counter == TIMEOUT-1: o_timeout=1 for the next cycle, then go to GAP.
    - If rise and the timeout condition occur in the same cycle, completion wins and no timeout is flagged.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Requester contract: drop i_req, or present a new byte, on the edge after seeing o_ack. The next sample of i_req is ≥2+GAP_CYCLES cycles later, so no double accept is possible.
- i_req changes outside IDLE are ignored. A request that drops before being granted is lost silently.
- Counter widths: wait counter clog2(TIMEOUT+1), gap counter clog2(GAP_CYCLES+1). Both saturate and never wrap.

## Timing
- All outputs are registered.
- i_req[k] high in IDLE at edge t gives LAUNCH in cycle t+1: o_ack[k] and o_tx_en high for exactly one cycle, o_tx_d already valid.
- o_tx_d is stable from the LAUNCH cycle through the end of the GAP.
- Completion rise sampled at edge c gives GAP from c+1 to c+GAP_CYCLES, then IDLE. The earliest next o_tx_en is at c+GAP_CYCLES+2.
- Timeout: o_timeout is high in the cycle TIMEOUT+1 after the LAUNCH cycle. That cycle is the first GAP cycle.
- o_busy is high from LAUNCH through the last GAP cycle inclusive.
- Maximum back-to-back throughput is one byte per (frame time + GAP_CYCLES + 2) cycles.

## Test plan
Benches use a serializer model that raises o_tx_complete for 1 cycle, 4340 cycles after i_tx_en, unless noted.
- Single request: i_req=0001, byte 0x55 → one o_ack[0] pulse coincident with o_tx_en, o_tx_d=0x55, o_busy falls GAP_CYCLES+1 cycles after completion, o_grant_idx=0.
- Simultaneous: i_req=1111 from reset, bytes 0xA0..0xA3, each requester drops after its ack → grants in order 0,1,2,3, bytes 0xA0,0xA1,0xA2,0xA3, four o_tx_en pulses, no o_timeout.
- Fairness: requesters 1 and 2 hold i_req continuously (re-assert after each ack) for 6 frames → grant sequence 1,2,1,2,1,2.
- Timeout: TIMEOUT=16, model never completes → o_timeout pulse in the 17th cycle after LAUNCH, return to IDLE after GAP, next pending request granted normally.
- Race and stale: TIMEOUT=16, completion rise on the cycle the counter hits 15 → no o_timeout. A completion rise during IDLE or GAP is ignored, with no state change.
- Reset mid-WAIT: assert rst_n=0 500 cycles into a frame → o_tx_en, o_ack, o_busy, o_tx_d drop to 0 immediately (async). After release, requester 0 wins over pending requester 3.
